// File: rtl/fpnew_pkg.sv
// Minimal slice of the FPU package: only the IEEE exception status type
// that the writeback buffer stores alongside each result.
package fpnew_pkg;

  typedef struct packed {
    logic nv;  // invalid operation
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

endpackage

// File: rtl/fpu_wb_pkg.sv
// Shared types and constants for the FPU writeback buffer.
package fpu_wb_pkg;

  import fpnew_pkg::*;

  localparam int unsigned FFLAGS_W     = 5;
  localparam int unsigned WB_RESULT_W  = 32;
  localparam int unsigned WB_TAG_W     = 5;

  // Entry layout at the default FPU configuration; the top rebuilds it from
  // its own parameters so other widths stay consistent.
  typedef struct packed {
    logic [WB_RESULT_W-1:0] result;
    status_t                status;
    logic [WB_TAG_W-1:0]    tag;
  } wb_entry_t;

  function automatic logic [FFLAGS_W-1:0] status_bits(input status_t s);
    return {s.nv, s.dz, s.of, s.uf, s.nx};
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic in-order FIFO with wrapping pointers, an occupancy counter and flush.
module fpu_wb_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4,
  localparam int unsigned PtrW     = $clog2(Depth),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntW-1:0]      count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Flush wins over any transfer in the same cycle.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset: contents are only observed when count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fpu_wb_buffer.sv
// FPU result buffer feeding register-file writeback, with sticky fflags
// accrued when results retire.
module fpu_wb_buffer
  import fpnew_pkg::*;
  import fpu_wb_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned TagWidth = 5,
  parameter int unsigned Depth    = 4,
  localparam int unsigned CntW    = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    in_result_i,
  input  logic [FFLAGS_W-1:0] in_status_i,
  input  logic [TagWidth-1:0] in_tag_i,
  input  logic                flush_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [Width-1:0]    wb_result_o,
  output logic [TagWidth-1:0] wb_tag_o,
  output logic [FFLAGS_W-1:0] fflags_o,
  input  logic                fflags_we_i,
  input  logic [FFLAGS_W-1:0] fflags_wdata_i,
  output logic [CntW-1:0]     count_o,
  output logic                busy_o
);

  typedef struct packed {
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  entry_t              in_entry, head;
  logic                full, empty, push, pop;
  logic [FFLAGS_W-1:0] fflags_q, fflags_d;

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high. in_ready depends only on occupancy (never on wb_ready), and
  // wb_valid is masked by flush so flushed entries are never written back.
  assign in_ready_o = ~full;
  assign wb_valid_o = ~empty & ~flush_i;
  assign push       = in_valid_i & in_ready_o & ~flush_i;
  assign pop        = wb_valid_o & wb_ready_i;
  assign busy_o     = ~empty;

  assign in_entry.result = in_result_i;
  assign in_entry.status = status_t'(in_status_i);
  assign in_entry.tag    = in_tag_i;

  fpu_wb_fifo #(
    .DataWidth(EntryW),
    .Depth    (Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush_i),
    .data_i (in_entry),
    .data_o (head),
    .count_o(count_o),
    .full_o (full),
    .empty_o(empty)
  );

  assign wb_result_o = head.result;
  assign wb_tag_o    = head.tag;

  // Flags accrue on retirement, so a CSR write never hides a popped flag.
  always_comb begin
    fflags_d = fflags_we_i ? fflags_wdata_i : fflags_q;
    if (pop) fflags_d = fflags_d | status_bits(head.status);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fflags_q <= '0;
    else       fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Bench for fpu_wb_buffer: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_fpu_wb_buffer;

  localparam int W  = 32;
  localparam int TW = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          in_valid_i, in_ready_o;
  logic [W-1:0]  in_result_i;
  logic [4:0]    in_status_i;
  logic [TW-1:0] in_tag_i;
  logic          flush_i;
  logic          wb_valid_o, wb_ready_i;
  logic [W-1:0]  wb_result_o;
  logic [TW-1:0] wb_tag_o;
  logic [4:0]    fflags_o;
  logic          fflags_we_i;
  logic [4:0]    fflags_wdata_i;
  logic [CW-1:0] count_o;
  logic          busy_o;

  fpu_wb_buffer #(.Width(W), .TagWidth(TW), .Depth(D)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_result_i   (in_result_i),
    .in_status_i   (in_status_i),
    .in_tag_i      (in_tag_i),
    .flush_i       (flush_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_result_o   (wb_result_o),
    .wb_tag_o      (wb_tag_o),
    .fflags_o      (fflags_o),
    .fflags_we_i   (fflags_we_i),
    .fflags_wdata_i(fflags_wdata_i),
    .count_o       (count_o),
    .busy_o        (busy_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // reference model: in-order queues of buffered results plus sticky flags
  logic [W-1:0]  exp_q[$];
  logic [4:0]    exp_st_q[$];
  logic [TW-1:0] exp_tag_q[$];
  logic [4:0]    m_fflags;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_st_q.delete();
    exp_tag_q.delete();
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("in_ready", in_ready_o, n != D);
    check("count", count_o, n);
    check("busy", busy_o, n != 0);
    check("wb_valid", wb_valid_o, (n != 0) && !flush_i);
    check("fflags", fflags_o, m_fflags);
    if (n != 0 && !flush_i) begin
      check("wb_result", wb_result_o, exp_q[0]);
      check("wb_tag", wb_tag_o, exp_tag_q[0]);
    end
  endtask

  // driver: one clock cycle of stimulus, checked at the falling edge
  task automatic cycle(input logic v, input logic [W-1:0] r, input logic [4:0] s,
                       input logic [TW-1:0] t, input logic fl, input logic rdy,
                       input logic we, input logic [4:0] wd);
    int  n;
    logic push, pop;
    in_valid_i = v; in_result_i = r; in_status_i = s; in_tag_i = t;
    flush_i = fl; wb_ready_i = rdy; fflags_we_i = we; fflags_wdata_i = wd;
    @(negedge clk_i);
    check_outputs();
    n    = exp_q.size();
    push = v && (n != D) && !fl;
    pop  = (n != 0) && !fl && rdy;
    m_fflags = (we ? wd : m_fflags) | (pop ? exp_st_q[0] : 5'b0);
    if (fl) model_clear();
    else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(exp_st_q.pop_front());
        void'(exp_tag_q.pop_front());
      end
      if (push) begin
        exp_q.push_back(r);
        exp_st_q.push_back(s);
        exp_tag_q.push_back(t);
      end
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0; flush_i = 1'b0; fflags_we_i = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, 5'd0, '0, 1'b0, rdy, 1'b0, 5'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    in_valid_i = 0; in_result_i = 0; in_status_i = 0; in_tag_i = 0;
    flush_i = 0; wb_ready_i = 0; fflags_we_i = 0; fflags_wdata_i = 0;
    m_fflags = 5'd0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // reset state
    check("rst_valid", wb_valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fflags", fflags_o, 0);
    check("rst_ready", in_ready_o, 1);

    // single result, flags accrue only on pop
    cycle(1'b1, 32'h3F80_0000, 5'h01, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0);
    check("t1_valid", wb_valid_o, 1);
    check("t1_result", wb_result_o, 32'h3F80_0000);
    check("t1_tag", wb_tag_o, 3);
    check("t1_fflags_before", fflags_o, 0);
    idle(1'b1);
    check("t1_fflags_after", fflags_o, 5'h01);
    check("t1_count", count_o, 0);

    // fill to capacity, fifth push refused, ordered drain
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 32'h1000 + i, 5'd0, TW'(i), 1'b0, 1'b0, 1'b0, 5'd0);
    check("full_ready", in_ready_o, 0);
    check("full_count", count_o, 4);
    cycle(1'b1, 32'hDEAD, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0);
    check("full_count_after5", count_o, 4);
    for (int i = 1; i <= 4; i++) begin
      check("drain_tag", wb_tag_o, i);
      idle(1'b1);
    end
    check("drain_empty", count_o, 0);

    // streaming one in / one out across pointer wrap
    cycle(1'b1, 32'h2000, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int i = 1; i <= 9; i++) begin
      check("stream_count", count_o, 1);
      check("stream_tag", wb_tag_o, i - 1);
      cycle(1'b1, 32'h2000 + i, 5'd0, TW'(i), 1'b0, 1'b1, 1'b0, 5'd0);
    end
    check("stream_last_tag", wb_tag_o, 9);
    idle(1'b1);

    // flush discards entries and their flags, and drops a same-cycle push
    cycle(1'b0, '0, 5'd0, '0, 1'b0, 1'b0, 1'b1, 5'd0);
    check("csr_clear", fflags_o, 0);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h3000 + i, 5'h10, TW'(i), 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, 32'h3FFF, 5'h10, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0);
    check("flush_count", count_o, 0);
    check("flush_valid", wb_valid_o, 0);
    check("flush_fflags", fflags_o, 0);

    // CSR write in the same cycle as a pop keeps the popped flag
    cycle(1'b1, 32'h4000, 5'h02, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, '0, 5'd0, '0, 1'b0, 1'b1, 1'b1, 5'h04);
    check("csr_pop_merge", fflags_o, 5'h06);

    // asynchronous reset with entries held
    cycle(1'b1, 32'h5000, 5'h08, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, 32'h5001, 5'h08, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0);
    check("pre_rst_count", count_o, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", wb_valid_o, 0);
    check("arst_count", count_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_fflags", fflags_o, 0);
    check("arst_ready", in_ready_o, 1);
    model_clear();
    m_fflags = 5'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    repeat (3) idle(1'b1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
            TW'($urandom_range(0, 31)), $urandom_range(0, 31) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
            5'($urandom_range(0, 31)));
    end
    repeat (D + 1) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
